// File: rtl/multi_channel_accumulator_if.sv
// Readout stream between the accumulator (master) and its stats/CSR consumer (slave).
interface multi_channel_accumulator_if #(
  parameter int unsigned CH_W      = 3,
  parameter int unsigned ACC_WIDTH = 40
);
  logic                 o_VALID;
  logic                 i_READY;
  logic [CH_W-1:0]      o_CHAN;
  logic [ACC_WIDTH-1:0] o_DATA;

  modport master (output o_VALID, o_CHAN, o_DATA, input  i_READY);
  modport slave  (input  o_VALID, o_CHAN, o_DATA, output i_READY);
endinterface

// File: rtl/multi_channel_accumulator.sv
// CHANNELS independent running sums with wrap/saturate arithmetic, sticky overflow
// flags and a valid/ready engine that streams every total out on i_DUMP.
module multi_channel_accumulator #(
  parameter int unsigned  DATA_WIDTH    = 32,
  parameter int unsigned  ACC_WIDTH     = 40,
  parameter int unsigned  CHANNELS      = 4,
  parameter bit           SATURATE      = 1'b0,
  parameter bit           CLEAR_ON_READ = 1'b0,
  // One spare code so out-of-range channel indices are always expressible.
  localparam int unsigned CH_W          = $clog2(CHANNELS + 1)
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_N,
  input  logic                  i_ENABLE,
  input  logic [CH_W-1:0]       i_CHANNEL,
  input  logic [DATA_WIDTH-1:0] i_DATA_IN,
  input  logic                  i_CLEAR,
  input  logic                  i_DUMP,
  multi_channel_accumulator_if.master rd_if,
  output logic                  o_BUSY,
  output logic [CHANNELS-1:0]   o_OVERFLOW
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t                       r_state;
  state_t                       w_next_state;
  logic                         r_valid;
  logic                         r_busy;
  logic [CH_W-1:0]              r_chan;
  logic [ACC_WIDTH-1:0]         r_data;
  logic                         w_xfer;
  logic                         w_last;
  logic                         w_capture;
  logic                         w_finish;
  logic [CH_W-1:0]              w_cap_chan;
  logic [ACC_WIDTH-1:0]         w_cap_data;
  logic [CHANNELS*ACC_WIDTH-1:0] w_acc_flat;

  assign w_xfer = r_valid && rd_if.i_READY;
  assign w_last = (r_chan == CH_W'(CHANNELS - 1));

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_DUMP)           w_next_state = S_SEND;
      S_SEND:  if (w_xfer && w_last) w_next_state = S_IDLE;
      default:                       w_next_state = S_IDLE;
    endcase
  end

  // Capture strobe and target channel; i_DUMP only matters in IDLE.
  always_comb begin
    w_capture  = 1'b0;
    w_finish   = 1'b0;
    w_cap_chan = '0;
    case (r_state)
      S_IDLE: begin
        if (i_DUMP) w_capture = 1'b1;
      end
      S_SEND: begin
        if (w_xfer && !w_last) begin
          w_capture  = 1'b1;
          w_cap_chan = r_chan + CH_W'(1);
        end
        if (w_xfer && w_last) w_finish = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_cap_data = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (w_cap_chan == CH_W'(ch)) w_cap_data = w_acc_flat[ch*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Captured total is the pre-update accumulator value; it holds after the last transfer.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_chan  <= '0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_busy  <= 1'b1;
      r_chan  <= w_cap_chan;
      r_data  <= w_cap_data;
    end else if (w_finish) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end
  end

  assign rd_if.o_VALID = r_valid;
  assign rd_if.o_CHAN  = r_chan;
  assign rd_if.o_DATA  = r_data;
  assign o_BUSY        = r_busy;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic                 w_hit;
    logic                 w_rd_clr;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    assign w_hit    = i_ENABLE && (i_CHANNEL == CH_W'(g));
    assign w_rd_clr = CLEAR_ON_READ && w_capture && (w_cap_chan == CH_W'(g));
    assign w_sum    = {1'b0, r_acc} + (ACC_WIDTH+1)'(i_DATA_IN);

    // Clear beats clear-on-read, which beats accumulate except that a same-cycle sample survives it.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (i_CLEAR) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (w_rd_clr) begin
        r_acc <= w_hit ? ACC_WIDTH'(i_DATA_IN) : '0;
        r_ovf <= 1'b0;
      end else if (w_hit) begin
        if (w_sum[ACC_WIDTH]) begin
          r_ovf <= 1'b1;
          r_acc <= SATURATE ? '1 : w_sum[ACC_WIDTH-1:0];
        end else begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
        end
      end
    end

    assign w_acc_flat[g*ACC_WIDTH +: ACC_WIDTH] = r_acc;
    assign o_OVERFLOW[g]                        = r_ovf;
  end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Four accumulator configurations share one random/directed stimulus stream; a queue-based
// scoreboard checks every readout against an arithmetic model of the channel totals.
module tb_multi_channel_accumulator;
  localparam int NI = 4;
  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, dump, ready;
  logic [2:0]  chan;
  logic [31:0] din;

  logic        valid_o [NI];
  logic        busy_o  [NI];
  logic [2:0]  chan_o  [NI];
  logic [39:0] data_o  [NI];
  logic [3:0]  ovf_o   [NI];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Instance configs: 0 default, 1 8-bit wrap, 2 8-bit saturate, 3 8-bit clear-on-read.
  function automatic int aw_of(int i);
    return (i == 0) ? 40 : 8;
  endfunction
  function automatic bit sat_of(int i);
    return (i == 2);
  endfunction
  function automatic bit cor_of(int i);
    return (i == 3);
  endfunction

  multi_channel_accumulator_if #(.CH_W(3), .ACC_WIDTH(40)) if0 ();
  multi_channel_accumulator_if #(.CH_W(3), .ACC_WIDTH(8))  if1 ();
  multi_channel_accumulator_if #(.CH_W(3), .ACC_WIDTH(8))  if2 ();
  multi_channel_accumulator_if #(.CH_W(3), .ACC_WIDTH(8))  if3 ();

  assign if0.i_READY = ready;
  assign if1.i_READY = ready;
  assign if2.i_READY = ready;
  assign if3.i_READY = ready;

  multi_channel_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(40), .CHANNELS(4),
    .SATURATE(1'b0), .CLEAR_ON_READ(1'b0)) u_dut0 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_ENABLE(en), .i_CHANNEL(chan), .i_DATA_IN(din),
    .i_CLEAR(clr), .i_DUMP(dump), .rd_if(if0), .o_BUSY(busy_o[0]), .o_OVERFLOW(ovf_o[0]));

  multi_channel_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(8), .CHANNELS(4),
    .SATURATE(1'b0), .CLEAR_ON_READ(1'b0)) u_dut1 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_ENABLE(en), .i_CHANNEL(chan), .i_DATA_IN(din[7:0]),
    .i_CLEAR(clr), .i_DUMP(dump), .rd_if(if1), .o_BUSY(busy_o[1]), .o_OVERFLOW(ovf_o[1]));

  multi_channel_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(8), .CHANNELS(4),
    .SATURATE(1'b1), .CLEAR_ON_READ(1'b0)) u_dut2 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_ENABLE(en), .i_CHANNEL(chan), .i_DATA_IN(din[7:0]),
    .i_CLEAR(clr), .i_DUMP(dump), .rd_if(if2), .o_BUSY(busy_o[2]), .o_OVERFLOW(ovf_o[2]));

  multi_channel_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(8), .CHANNELS(4),
    .SATURATE(1'b0), .CLEAR_ON_READ(1'b1)) u_dut3 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_ENABLE(en), .i_CHANNEL(chan), .i_DATA_IN(din[7:0]),
    .i_CLEAR(clr), .i_DUMP(dump), .rd_if(if3), .o_BUSY(busy_o[3]), .o_OVERFLOW(ovf_o[3]));

  assign valid_o[0] = if0.o_VALID;  assign chan_o[0] = if0.o_CHAN;  assign data_o[0] = if0.o_DATA;
  assign valid_o[1] = if1.o_VALID;  assign chan_o[1] = if1.o_CHAN;  assign data_o[1] = 40'(if1.o_DATA);
  assign valid_o[2] = if2.o_VALID;  assign chan_o[2] = if2.o_CHAN;  assign data_o[2] = 40'(if2.o_DATA);
  assign valid_o[3] = if3.o_VALID;  assign chan_o[3] = if3.o_CHAN;  assign data_o[3] = 40'(if3.o_DATA);

  task automatic chk(string name, int inst, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got 0x%0h expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Reference model: plain-integer channel totals plus the readout position.
  longint unsigned m_acc [NI][CH];
  logic [3:0]      m_ovf [NI];
  bit              m_busy;
  int              m_pos;
  bit [47:0]       exp_q [NI][$];

  task automatic model_step();
    bit              cap, done, hit;
    int              cc;
    longint unsigned lim, d, s;
    cap = 1'b0; done = 1'b0; cc = 0;
    if (!m_busy) begin
      if (dump) cap = 1'b1;
    end else if (ready) begin
      if (m_pos < CH - 1) begin cap = 1'b1; cc = m_pos + 1; end
      else done = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      lim = 64'd1 << aw_of(i);
      d   = (i == 0) ? 64'(din) : 64'(din[7:0]);
      if (cap) exp_q[i].push_back({8'(cc), 40'(m_acc[i][cc])});
      for (int c = 0; c < CH; c++) begin
        hit = en && (int'(chan) == c);
        if (clr) begin
          m_acc[i][c] = 0; m_ovf[i][c] = 1'b0;
        end else if (cap && cor_of(i) && cc == c) begin
          m_acc[i][c] = hit ? d : 0; m_ovf[i][c] = 1'b0;
        end else if (hit) begin
          s = m_acc[i][c] + d;
          if (s >= lim) begin
            m_ovf[i][c] = 1'b1;
            m_acc[i][c] = sat_of(i) ? lim - 1 : s - lim;
          end else begin
            m_acc[i][c] = s;
          end
        end
      end
    end
    if (cap)  begin m_busy = 1'b1; m_pos = cc; end
    if (done) m_busy = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        for (int c = 0; c < CH; c++) m_acc[i][c] = 0;
        m_ovf[i] = 4'b0;
        exp_q[i].delete();
      end
      m_busy = 1'b0;
      m_pos  = 0;
    end else begin
      model_step();
    end
  end

  // Monitor: compares presented totals with the queue head, pops on each transfer.
  logic [2:0]  last_ch [NI];
  logic [39:0] last_d  [NI];

  always @(negedge clk) begin
    bit [47:0] e;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin last_ch[i] = 3'd0; last_d[i] = 40'd0; end
    end else begin
      for (int i = 0; i < NI; i++) begin
        chk("busy",     i, 64'(busy_o[i]),  64'(m_busy));
        chk("valid",    i, 64'(valid_o[i]), 64'(m_busy));
        chk("overflow", i, 64'(ovf_o[i]),   64'(m_ovf[i]));
        if (valid_o[i]) begin
          chk("exp_avail", i, 64'(exp_q[i].size() != 0), 64'd1);
          if (exp_q[i].size() != 0) begin
            e = exp_q[i][0];
            chk("chan", i, 64'(chan_o[i]), 64'(e[47:40]));
            chk("data", i, 64'(data_o[i]), 64'(e[39:0]));
            if (ready) begin
              void'(exp_q[i].pop_front());
              last_ch[i] = e[42:40];
              last_d[i]  = e[39:0];
            end
          end
        end else begin
          chk("hold_chan", i, 64'(chan_o[i]), 64'(last_ch[i]));
          chk("hold_data", i, 64'(data_o[i]), 64'(last_d[i]));
        end
      end
    end
  end

  task automatic cyc(bit e, int c, longint unsigned d, bit cl, bit du, bit rd);
    en = e; chan = 3'(c); din = 32'(d); clr = cl; dump = du; ready = rd;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic dump_drain();
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    idle(6);
  endtask

  task automatic reset_checks();
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", i, 64'(valid_o[i]), 64'd0);
      chk("rst_busy",  i, 64'(busy_o[i]),  64'd0);
      chk("rst_chan",  i, 64'(chan_o[i]),  64'd0);
      chk("rst_data",  i, 64'(data_o[i]),  64'd0);
      chk("rst_ovf",   i, 64'(ovf_o[i]),   64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; chan = 3'd0; din = 32'd0; clr = 1'b0; dump = 1'b0; ready = 1'b1;
    #1;
    reset_checks();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Three samples into channel 2, then stream all totals.
    cyc(1'b1, 2, 100, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 2, 200, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 2, 300, 1'b0, 1'b0, 1'b1);
    dump_drain();

    // 8-bit overflow: 200 + 100 wraps to 44 or clamps at 255.
    cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1, 200, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1, 100, 1'b0, 1'b0, 1'b1);
    dump_drain();

    // Back-pressure while channel 0 keeps accumulating.
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 0, 5, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Capture and accumulate on channel 0 in the same cycle.
    cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 0, 7, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 0, 9, 1'b0, 1'b1, 1'b1);
    idle(6);
    dump_drain();

    // Reset while channel 1 is on the bus, then a fresh dump from channel 0.
    cyc(1'b1, 1, 11, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_checks();
    idle(2);
    rst_n = 1'b1;
    cyc(1'b1, 3, 20, 1'b0, 1'b0, 1'b1);
    dump_drain();

    // Clear wins over a same-cycle sample; out-of-range channels are ignored.
    cyc(1'b1, 3, 50, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 3, 50, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 4, 77, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 7, 77, 1'b0, 1'b0, 1'b1);
    dump_drain();

    // Wide-accumulator overflow on channel 0.
    cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 257; k++) cyc(1'b1, 0, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    dump_drain();

    // Random traffic including clears, dumps and back-pressure during readout.
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 64'($urandom) : 64'($urandom_range(0, 300)),
          $urandom_range(0, 99) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0);
    end
    idle(10);
    for (int i = 0; i < NI; i++) chk("queue_drained", i, 64'(exp_q[i].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
